// File: rtl/trace_capture_if.sv
// Signal bundle between the sample source / VGA timing side and the trace capture controller.
// Samples are consumed on every cycle where i_sample_valid is high; there is no ready/backpressure.
interface trace_capture_if #(
  parameter int SAMPLE_W = 8
);
  logic [SAMPLE_W-1:0] i_sample;
  logic                i_sample_valid;
  logic [SAMPLE_W-1:0] i_trig_level;
  logic                i_trig_falling;
  logic                i_single;
  logic                i_arm;
  logic [9:0]          i_coord_x;
  logic [9:0]          i_coord_y;
  logic                o_pixel_on;
  logic [1:0]          o_state;
  logic                o_front_sel;

  modport master (
    output i_sample, i_sample_valid, i_trig_level, i_trig_falling,
    output i_single, i_arm, i_coord_x, i_coord_y,
    input  o_pixel_on, o_state, o_front_sel
  );

  modport slave (
    input  i_sample, i_sample_valid, i_trig_level, i_trig_falling,
    input  i_single, i_arm, i_coord_x, i_coord_y,
    output o_pixel_on, o_state, o_front_sel
  );
endinterface

// File: rtl/trace_capture_ctrl.sv
// Oscilloscope trace capture: trigger, capture one line of samples into the back buffer,
// swap buffers at the frame boundary and answer the per-pixel "trace lit" question.
module trace_capture_ctrl #(
  parameter int SAMPLE_W = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  trace_capture_if.slave bus
);
  localparam int IDX_W = $clog2(H_ACTIVE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_wr_idx;
  logic [IDX_W-1:0]    w_wr_idx_nxt;
  logic [IDX_W-1:0]    w_wr_addr;
  logic [IDX_W-1:0]    w_rd_addr;
  logic                w_wr_en;
  logic                w_do_swap;
  logic                w_rise;
  logic                w_fall;
  logic                w_trig;
  logic                w_swap_evt;
  logic [SAMPLE_W-1:0] r_prev;
  logic                r_prev_valid;
  logic                r_front_sel;
  logic                r_front_valid;
  logic                r_pixel_on;
  logic [SAMPLE_W-1:0] r_buf0 [H_ACTIVE];
  logic [SAMPLE_W-1:0] r_buf1 [H_ACTIVE];
  logic [SAMPLE_W-1:0] w_rd_data;
  logic [9:0]          w_row;
  logic                w_pixel_hit;

  // Edge detection compares the last sample seen while armed against the live level.
  assign w_rise = r_prev_valid && (r_prev < bus.i_trig_level) && (bus.i_sample >= bus.i_trig_level);
  assign w_fall = r_prev_valid && (r_prev > bus.i_trig_level) && (bus.i_sample <= bus.i_trig_level);
  assign w_trig = bus.i_sample_valid && (bus.i_trig_falling ? w_fall : w_rise);
  assign w_swap_evt = (bus.i_coord_x == 10'd0) && (bus.i_coord_y == 10'(V_ACTIVE));

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_wr_idx;
    w_wr_idx_nxt = r_wr_idx;
    w_do_swap    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!bus.i_single || bus.i_arm) w_state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (w_trig) begin
          w_wr_en      = 1'b1;
          w_wr_addr    = '0;
          w_wr_idx_nxt = IDX_W'(1);
          w_state_nxt  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (bus.i_sample_valid) begin
          w_wr_en = 1'b1;
          if (r_wr_idx == IDX_W'(H_ACTIVE - 1)) begin
            w_wr_idx_nxt = '0;
            w_state_nxt  = ST_DONE;
          end else begin
            w_wr_idx_nxt = r_wr_idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        // A swap coinciding with the final write is not seen here, so it waits a frame.
        if (w_swap_evt) begin
          w_do_swap   = 1'b1;
          w_state_nxt = bus.i_single ? ST_IDLE : ST_ARMED;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_wr_idx      <= '0;
      r_prev        <= '0;
      r_prev_valid  <= 1'b0;
      r_front_sel   <= 1'b0;
      r_front_valid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_wr_idx <= w_wr_idx_nxt;
      if (r_state == ST_ARMED) begin
        if (bus.i_sample_valid) begin
          r_prev       <= bus.i_sample;
          r_prev_valid <= 1'b1;
        end
      end else begin
        r_prev_valid <= 1'b0;
      end
      if (w_do_swap) begin
        r_front_sel   <= ~r_front_sel;
        r_front_valid <= 1'b1;
      end
    end
  end

  // Writer owns the back buffer, reader owns the front buffer; they never share a port.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      if (r_front_sel) r_buf0[w_wr_addr] <= bus.i_sample;
      else             r_buf1[w_wr_addr] <= bus.i_sample;
    end
  end

  assign w_rd_addr   = (bus.i_coord_x < 10'(H_ACTIVE)) ? bus.i_coord_x[IDX_W-1:0] : '0;
  assign w_rd_data   = r_front_sel ? r_buf1[w_rd_addr] : r_buf0[w_rd_addr];
  assign w_row       = 10'(V_ACTIVE - 1) - 10'(w_rd_data);
  assign w_pixel_hit = r_front_valid && (bus.i_coord_x < 10'(H_ACTIVE)) &&
                       (bus.i_coord_y < 10'(V_ACTIVE)) && (bus.i_coord_y == w_row);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pixel_on <= 1'b0;
    else          r_pixel_on <= w_pixel_hit;
  end

  assign bus.o_state     = r_state;
  assign bus.o_front_sel = r_front_sel;
  assign bus.o_pixel_on  = r_pixel_on;
endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Bench for trace_capture_ctrl: directed scenarios plus randomized traffic against a
// queue-based reference model of the capture/swap/display rules.
module tb_trace_capture_ctrl;
  localparam int SW = 8;
  localparam int H  = 640;
  localparam int V  = 480;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trace_capture_if #(.SAMPLE_W(SW)) bus ();

  trace_capture_ctrl #(.SAMPLE_W(SW), .H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;

  logic [SW-1:0] exp_q[$];   // samples captured so far in the current back-buffer fill
  int  m_front[H];           // contents of the displayed buffer
  int  m_ph   = 0;           // expected o_state value
  int  m_prev = 0;
  bit  m_pv   = 0;
  bit  m_fs   = 0;
  bit  m_fv   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_pixel(input int x, input int y);
    if (!m_fv || x >= H || y >= V) return 1'b0;
    return y == (V - 1 - m_front[x]);
  endfunction

  task automatic model_reset();
    m_ph = 0; m_pv = 0; m_fs = 0; m_fv = 0;
    exp_q.delete();
  endtask

  task automatic model_update();
    int  s, lvl;
    bit  hit;
    s   = int'(bus.i_sample);
    lvl = int'(bus.i_trig_level);
    if (m_ph == 0) begin
      if (!bus.i_single || bus.i_arm) begin m_ph = 1; m_pv = 0; end
    end else if (m_ph == 1) begin
      if (bus.i_sample_valid) begin
        hit = m_pv && (bus.i_trig_falling ? (m_prev > lvl && s <= lvl)
                                          : (m_prev < lvl && s >= lvl));
        if (hit) begin
          exp_q.delete();
          exp_q.push_back(bus.i_sample);
          m_ph = 2;
        end else begin
          m_prev = s; m_pv = 1;
        end
      end
    end else if (m_ph == 2) begin
      if (bus.i_sample_valid) begin
        exp_q.push_back(bus.i_sample);
        if (exp_q.size() == H) m_ph = 3;
      end
    end else begin
      if (bus.i_coord_x == 0 && bus.i_coord_y == V) begin
        for (int i = 0; i < H; i++) m_front[i] = int'(exp_q[i]);
        exp_q.delete();
        m_fs = ~m_fs;
        m_fv = 1;
        m_pv = 0;
        m_ph = bus.i_single ? 0 : 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    bit exp_pix;
    @(posedge clk);
    exp_pix = rst_n && model_pixel(int'(bus.i_coord_x), int'(bus.i_coord_y));
    if (rst_n) model_update();
    #1;
    check("state", int'(bus.o_state), m_ph);
    check("front_sel", int'(bus.o_front_sel), int'(m_fs));
    check("pixel", int'(bus.o_pixel_on), int'(exp_pix));
  endtask

  task automatic set_coord(input int x, input int y);
    bus.i_coord_x = 10'(x);
    bus.i_coord_y = 10'(y);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_state", int'(bus.o_state), 0);
    check("rst_front_sel", int'(bus.o_front_sel), 0);
    check("rst_pixel", int'(bus.o_pixel_on), 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic do_swap();
    set_coord(0, V);
    tick();
    set_coord(1, 0);
  endtask

  task automatic probe(input string tag, input int x, input int y, input int exp);
    set_coord(x, y);
    tick();
    check(tag, int'(bus.o_pixel_on), exp);
  endtask

  task automatic feed(input int s);
    bus.i_sample_valid = 1'b1;
    bus.i_sample       = SW'(s);
    tick();
    bus.i_sample_valid = 1'b0;
  endtask

  // Ramp 0..255 repeating, advancing only on valid samples; returns cycles spent in CAPTURE.
  task automatic run_ramp(input bit half, output int cap_cycles);
    logic [SW-1:0] ramp;
    bit ph;
    ramp = '0; ph = 1'b1; cap_cycles = 0;
    set_coord(1, 0);
    for (int i = 0; i < 4000 && bus.o_state != 2'd3; i++) begin
      bus.i_sample_valid = half ? ph : 1'b1;
      bus.i_sample       = ramp;
      ph = ~ph;
      tick();
      if (bus.i_sample_valid) ramp++;
      if (bus.o_state == 2'd2) cap_cycles++;
    end
    bus.i_sample_valid = 1'b0;
    check("wait_done", int'(bus.o_state), 3);
  endtask

  task automatic pick_coord(input int swap_pct);
    int r, x, y;
    r = int'($urandom_range(0, 99));
    if (r < swap_pct) begin
      set_coord(0, V);
    end else if (r < 25) begin
      set_coord(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)));
    end else begin
      x = int'($urandom_range(0, H - 1));
      y = V - 1 - m_front[x] + int'($urandom_range(0, 2)) - 1;
      if (y < 0) y = 0;
      set_coord(x, y);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cap, sv;
    bus.i_sample = '0; bus.i_sample_valid = 1'b0;
    bus.i_trig_level = SW'(100); bus.i_trig_falling = 1'b0;
    bus.i_single = 1'b0; bus.i_arm = 1'b0;
    set_coord(1, 0);
    tick();
    tick();
    check("reset_state", int'(bus.o_state), 0);
    check("reset_front_sel", int'(bus.o_front_sel), 0);
    check("reset_pixel", int'(bus.o_pixel_on), 0);
    rst_n = 1'b1;

    // Auto mode, full-rate ramp, rising trigger at 100
    run_ramp(1'b0, cap);
    check("ramp_capture_cycles", cap, 639);
    do_swap();
    check("ramp_swap_fs", int'(bus.o_front_sel), 1);
    probe("ramp_col0_row379", 0, 379, 1);
    probe("ramp_col5_row374", 5, 374, 1);
    probe("ramp_col5_row375", 5, 375, 0);

    // Same ramp with every other sample invalid
    do_reset();
    run_ramp(1'b1, cap);
    check("half_capture_cycles", cap, 1278);
    do_swap();
    probe("half_col0_row379", 0, 379, 1);
    probe("half_col5_row374", 5, 374, 1);
    probe("half_col639_row252", 639, 252, 1);

    // Single shot: nothing happens without i_arm, even across frame boundaries
    do_reset();
    bus.i_single = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.i_sample_valid = 1'b1;
      bus.i_sample = SW'($urandom_range(0, 255));
      pick_coord(5);
      tick();
    end
    check("single_noarm_state", int'(bus.o_state), 0);
    probe("single_noarm_pixel", 0, 379, 0);
    bus.i_arm = 1'b1;
    tick();
    bus.i_arm = 1'b0;
    check("single_armed_state", int'(bus.o_state), 1);
    run_ramp(1'b0, cap);
    do_swap();
    check("single_back_idle", int'(bus.o_state), 0);
    probe("single_trace_kept", 0, 379, 1);
    do_swap();
    check("single_no_second_swap", int'(bus.o_front_sel), 1);

    // Falling trigger at 50: equal-to-level with prev == level must not fire
    do_reset();
    bus.i_single = 1'b0; bus.i_trig_falling = 1'b1; bus.i_trig_level = SW'(50);
    tick();
    feed(50); feed(50); feed(50);
    check("fall_eq_no_fire", int'(bus.o_state), 1);
    feed(60); feed(55);
    check("fall_55_no_fire", int'(bus.o_state), 1);
    feed(50);
    check("fall_fire_on_50", int'(bus.o_state), 2);

    // Final write lands on the swap coordinate: swap deferred one frame
    set_coord(1, 0);
    for (int i = 0; i < 3000 && exp_q.size() < H - 1; i++) begin
      bus.i_sample_valid = 1'($urandom_range(0, 1));
      bus.i_sample = SW'($urandom_range(0, 255));
      tick();
    end
    bus.i_sample_valid = 1'b1;
    bus.i_sample = SW'($urandom_range(0, 255));
    set_coord(0, V);
    tick();
    bus.i_sample_valid = 1'b0;
    check("coinc_state_done", int'(bus.o_state), 3);
    check("coinc_fs_held", int'(bus.o_front_sel), 0);
    set_coord(1, 0);
    tick();
    do_swap();
    check("coinc_next_swap_fs", int'(bus.o_front_sel), 1);

    // Reset in the middle of a capture while a lit pixel is on screen
    bus.i_trig_falling = 1'b0; bus.i_trig_level = SW'(100);
    sv = 0;
    for (int i = 0; i < 6000 && !(m_ph == 2 && exp_q.size() == 300); i++) begin
      bus.i_sample_valid = 1'b1;
      sv = (sv + 7) & 255;
      bus.i_sample = SW'(sv);
      set_coord(3, V - 1 - m_front[3]);
      tick();
    end
    check("midcap_pixel_lit", int'(bus.o_pixel_on), 1);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.i_sample_valid = 1'b1;
      bus.i_sample = SW'($urandom_range(0, 255));
      pick_coord(0);
      tick();
    end

    // Randomized traffic
    sv = 128;
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 199) == 0) bus.i_trig_level = SW'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) bus.i_trig_falling = ~bus.i_trig_falling;
      if ($urandom_range(0, 499) == 0) bus.i_single = ($urandom_range(0, 3) == 0);
      bus.i_arm = ($urandom_range(0, 29) == 0);
      bus.i_sample_valid = ($urandom_range(0, 3) != 0);
      sv = (sv + int'($urandom_range(0, 30)) - 15) & 255;
      bus.i_sample = SW'(sv);
      pick_coord(3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
